match_variant_sequencer: RTL

- Controller that sequences a combinational enum-match datapath: steps the variant selector through 0..NUM_VARIANTS-1 and samples the datapath result after a settle window.
- Compares each result against a programmable expected table and reports busy/done/pass, error count and first failing variant.
- Sits between a start/config source (CPU or bench) and the match datapath; the variant field drives the datapath's test-case input and the result feeds back in.

---
 rtl/match_variant_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/match_variant_sequencer.sv
// match_variant_sequencer: sweeps a variant selector over 0..NUM_VARIANTS-1,
// holds each variant for SETTLE cycles, then samples the datapath result and
// compares it against a programmable expected table. Reports busy/done/pass,
// a saturating error count and the first failing variant.
// Optional build macro: MATCH_SEQ_STOP_ON_FAIL_EN ends the sweep at the first
// mismatch instead of running every variant.
module match_variant_sequencer #(
    parameter int NUM_VARIANTS = 3,
    parameter int DATA_W       = 8,
    parameter int SETTLE       = 1
) (
    input  logic                    _i_clk,
    input  logic                    _i_rst_n,
    input  logic                    _i_start,
    input  logic [DATA_W-1:0]       _i_result,
    input  logic                    _i_exp_wr_en,
    input  logic [7:0]              _i_exp_wr_idx,
    input  logic [DATA_W-1:0]       _i_exp_wr_data,
    output logic [2*8+DATA_W+2:0]   __output
);

    localparam int IDX_W = (NUM_VARIANTS > 1) ? $clog2(NUM_VARIANTS) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [7:0] LAST_IDX = 8'(NUM_VARIANTS - 1);
    localparam logic [7:0] NO_FAIL  = 8'hFF;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t             state_q;
    logic [7:0]         idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  variant_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [7:0]         err_q;
    logic [7:0]         ff_q;
    logic [DATA_W-1:0]  exp_q [NUM_VARIANTS];

    logic               idle_like;
    logic               wr_ok;
    logic               mismatch;
    logic               last;
    logic               stop;
    logic [7:0]         err_d;
    logic [7:0]         ff_d;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign wr_ok     = idle_like && _i_exp_wr_en &&
                       ({1'b0, _i_exp_wr_idx} < 9'(NUM_VARIANTS));
    // idx_q never leaves 0..NUM_VARIANTS-1, so the narrowed index is safe
    assign mismatch  = (_i_result != exp_q[idx_q[IDX_W-1:0]]);
    assign last      = (idx_q == LAST_IDX);
    assign err_d     = (mismatch && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    assign ff_d      = (mismatch && (ff_q == NO_FAIL)) ? idx_q : ff_q;

`ifdef MATCH_SEQ_STOP_ON_FAIL_EN
    assign stop = mismatch;
`else
    assign stop = 1'b0;
`endif

    // Sweep control: start, settle countdown, sample/compare, finish
    always_ff @(posedge _i_clk) begin
        if (!_i_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 8'd0;
            cnt_q     <= '0;
            variant_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 8'd0;
            ff_q      <= NO_FAIL;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (_i_start) begin
                        state_q   <= DRIVE;
                        idx_q     <= 8'd0;
                        cnt_q     <= CNT_RELOAD;
                        variant_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        err_q     <= 8'd0;
                        ff_q      <= NO_FAIL;
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) state_q <= SAMPLE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                SAMPLE: begin
                    err_q <= err_d;
                    ff_q  <= ff_d;
                    if (last || stop) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= (err_d == 8'd0);
                        variant_q <= '0;
                    end else begin
                        state_q   <= DRIVE;
                        idx_q     <= idx_q + 8'd1;
                        variant_q <= DATA_W'(idx_q + 8'd1);
                        cnt_q     <= CNT_RELOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Expected table: cleared by reset, writable only while no sweep runs
    always_ff @(posedge _i_clk) begin
        if (!_i_rst_n) begin
            for (int i = 0; i < NUM_VARIANTS; i++) exp_q[i] <= '0;
        end else if (wr_ok) begin
            exp_q[_i_exp_wr_idx[IDX_W-1:0]] <= _i_exp_wr_data;
        end
    end

    assign __output = {variant_q, busy_q, done_q, pass_q, err_q, ff_q};

endmodule
